// File: rtl/buzzer_pkg.sv
// Shared constants for the buzzer tone generator: mode and note encodings,
// base note frequencies and the half-period helper.
package buzzer_pkg;

    localparam int unsigned MODE_W      = 2;
    localparam int unsigned NOTE_W      = 5;
    localparam int unsigned NUM_DEGREES = 7;

    typedef enum logic [MODE_W-1:0] {
        MODE_NORMAL = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_UP     = 2'b10,
        MODE_MUTE   = 2'b11
    } mode_e;

    localparam logic [NOTE_W-1:0] NOTE_REST      = 5'd0;
    localparam logic [NOTE_W-1:0] NOTE_LO_FIRST  = 5'd1;
    localparam logic [NOTE_W-1:0] NOTE_LO_LAST   = 5'd7;
    localparam logic [NOTE_W-1:0] NOTE_MID_FIRST = 5'd8;
    localparam logic [NOTE_W-1:0] NOTE_MID_LAST  = 5'd14;
    localparam logic [NOTE_W-1:0] NOTE_HI_FIRST  = 5'd15;
    localparam logic [NOTE_W-1:0] NOTE_HI_LAST   = 5'd21;

    // C4..B4 in milli-Hz
    localparam int unsigned BASE_MHZ [NUM_DEGREES] = '{
        261630, 293660, 329630, 349230, 392000, 440000, 493880
    };

    function automatic longint unsigned half_period(
        input longint unsigned clk_hz,
        input int unsigned     degree,
        input int              k
    );
        longint unsigned hp;
        hp = (clk_hz * 64'd1000) / (64'd2 * 64'(BASE_MHZ[degree]));
        if (k < 0) hp = hp << (-k);
        else       hp = hp >> k;
        return hp;
    endfunction

endpackage

// File: rtl/buzzer_if.sv
// Note/mode command inputs and speaker output of the buzzer.
interface buzzer_if;
    logic [buzzer_pkg::MODE_W-1:0] mode;
    logic [buzzer_pkg::NOTE_W-1:0] note;
    logic                          speaker;

    modport master (output mode, output note, input speaker);
    modport slave  (input mode, input note, output speaker);
endinterface

// File: rtl/buzzer_div.sv
// Programmable half-period divider producing a 50% square wave; clear and
// disable both force the wave low and the counter to zero.
module buzzer_div #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] half,
    output logic             wave
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wave_q, wave_d;

    // clear has priority over the toggle point so a new note restarts at phase 0
    always_comb begin
        cnt_d  = cnt_q;
        wave_d = wave_q;
        if (clr || !en) begin
            cnt_d  = '0;
            wave_d = 1'b0;
        end else if (cnt_q == half - CNT_W'(1)) begin
            cnt_d  = '0;
            wave_d = ~wave_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/buzzer.sv
// Square-wave tone generator: decodes note/octave, applies the mode octave
// shift and restarts the divider whenever (mode, note) changes.
module buzzer
    import buzzer_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned CNT_W  = 24
) (
    input  logic     clk,
    input  logic     rst_n,
    buzzer_if.slave  bus
);

    localparam logic [CNT_W-1:0] HP_C = CNT_W'(half_period(CLK_HZ, 0, 0));
    localparam logic [CNT_W-1:0] HP_D = CNT_W'(half_period(CLK_HZ, 1, 0));
    localparam logic [CNT_W-1:0] HP_E = CNT_W'(half_period(CLK_HZ, 2, 0));
    localparam logic [CNT_W-1:0] HP_F = CNT_W'(half_period(CLK_HZ, 3, 0));
    localparam logic [CNT_W-1:0] HP_G = CNT_W'(half_period(CLK_HZ, 4, 0));
    localparam logic [CNT_W-1:0] HP_A = CNT_W'(half_period(CLK_HZ, 5, 0));
    localparam logic [CNT_W-1:0] HP_B = CNT_W'(half_period(CLK_HZ, 6, 0));

    logic [MODE_W+NOTE_W-1:0] prev_q, prev_d;
    logic                     changed;
    logic                     audible;
    logic                     en;
    logic [2:0]               degree;
    logic [1:0]               oct_idx;
    logic [1:0]               msh_idx;
    logic [2:0]               k_idx;
    logic [CNT_W-1:0]         base;
    logic [CNT_W-1:0]         half;
    mode_e                    mode_s;

    assign mode_s = mode_e'(bus.mode);

    always_comb begin
        audible = 1'b1;
        degree  = '0;
        oct_idx = 2'd1;
        if (bus.note >= NOTE_LO_FIRST && bus.note <= NOTE_LO_LAST) begin
            degree  = 3'(bus.note - NOTE_LO_FIRST);
            oct_idx = 2'd0;
        end else if (bus.note >= NOTE_MID_FIRST && bus.note <= NOTE_MID_LAST) begin
            degree  = 3'(bus.note - NOTE_MID_FIRST);
            oct_idx = 2'd1;
        end else if (bus.note >= NOTE_HI_FIRST && bus.note <= NOTE_HI_LAST) begin
            degree  = 3'(bus.note - NOTE_HI_FIRST);
            oct_idx = 2'd2;
        end else begin
            audible = 1'b0;
        end

        case (mode_s)
            MODE_DOWN: msh_idx = 2'd0;
            MODE_UP:   msh_idx = 2'd2;
            default:   msh_idx = 2'd1;
        endcase

        // k_idx = k + 2, with k the effective octave offset in -2..+2
        k_idx = {1'b0, oct_idx} + {1'b0, msh_idx};

        case (degree)
            3'd0:    base = HP_C;
            3'd1:    base = HP_D;
            3'd2:    base = HP_E;
            3'd3:    base = HP_F;
            3'd4:    base = HP_G;
            3'd5:    base = HP_A;
            default: base = HP_B;
        endcase

        case (k_idx)
            3'd0:    half = base << 2;
            3'd1:    half = base << 1;
            3'd2:    half = base;
            3'd3:    half = base >> 1;
            default: half = base >> 2;
        endcase

        en      = audible && (mode_s != MODE_MUTE);
        prev_d  = {bus.mode, bus.note};
        changed = (prev_d != prev_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= '0;
        else        prev_q <= prev_d;
    end

    buzzer_div #(.CNT_W(CNT_W)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (changed),
        .half  (half),
        .wave  (bus.speaker)
    );

endmodule

// File: tb/tb_buzzer.sv
// Directed bench for buzzer at a scaled-down clock (CLK_HZ = 100 kHz), so
// every half period is the 100 MHz figure divided by 1000 and floored.
module tb_buzzer;
    import buzzer_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    buzzer_if bus ();

    buzzer #(.CLK_HZ(100_000), .CNT_W(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expects the change edge to have been set up; verifies clear, first rise, high and low phases
    task automatic measure(input string tag, input int exp_half);
        int n;
        int limit;
        limit = 4 * exp_half + 16;
        @(posedge clk); #1;
        check({tag, "_clr"}, 32'(bus.speaker), 0);
        n = 0;
        while (bus.speaker !== 1'b1 && n < limit) begin @(posedge clk); #1; n++; end
        check({tag, "_rise"}, n, exp_half);
        n = 0;
        while (bus.speaker !== 1'b0 && n < limit) begin @(posedge clk); #1; n++; end
        check({tag, "_high"}, n, exp_half);
        n = 0;
        while (bus.speaker !== 1'b1 && n < limit) begin @(posedge clk); #1; n++; end
        check({tag, "_low"}, n, exp_half);
    endtask

    task automatic tone(input string tag, input logic [1:0] m, input logic [4:0] nt, input int exp_half);
        @(negedge clk);
        bus.mode = m;
        bus.note = nt;
        measure(tag, exp_half);
    endtask

    task automatic silent(input string tag, input logic [1:0] m, input logic [4:0] nt, input int cycles);
        int hi;
        int nz;
        @(negedge clk);
        bus.mode = m;
        bus.note = nt;
        @(posedge clk); #1;
        check({tag, "_first"}, 32'(bus.speaker), 0);
        hi = 0;
        nz = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (bus.speaker !== 1'b0) hi++;
            if (dut.u_div.cnt_q !== '0) nz++;
        end
        check({tag, "_hold"}, hi, 0);
        check({tag, "_cnt"}, nz, 0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        bus.mode = MODE_NORMAL;
        bus.note = NOTE_REST;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_spk", 32'(bus.speaker), 0);
        check("rst_cnt", 32'(dut.u_div.cnt_q), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        tone("a4", MODE_NORMAL, 5'd13, 113);
        // land the note change exactly on the low-to-high toggle point
        repeat (225) @(posedge clk);
        tone("a4_to_c4", MODE_NORMAL, 5'd8, 191);

        tone("a4_down", MODE_DOWN, 5'd13, 226);
        tone("a4_up", MODE_UP, 5'd13, 56);
        tone("c3_down", MODE_DOWN, 5'd1, 764);
        silent("rest", MODE_NORMAL, NOTE_REST, 1500);
        tone("b3", MODE_NORMAL, 5'd7, 202);
        tone("b4", MODE_NORMAL, 5'd14, 101);
        silent("note22", MODE_NORMAL, 5'd22, 600);
        tone("c5", MODE_NORMAL, 5'd15, 95);
        tone("b5_up", MODE_UP, 5'd21, 25);
        silent("note25", MODE_NORMAL, 5'd25, 600);
        tone("a4_again", MODE_NORMAL, 5'd13, 113);
        silent("mute", MODE_MUTE, 5'd13, 1500);

        tone("a4_pre_rst", MODE_NORMAL, 5'd13, 113);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_spk", 32'(bus.speaker), 0);
        check("midrst_cnt", 32'(dut.u_div.cnt_q), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        measure("rst_release", 113);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
